// File: rtl/vexp_range_reduce.sv
// Range reduction for vector exp: x -> (q, r) with e^x = 2^q * e^r, three-stage pipeline.
// Optional VEXP_RR_ROUND_EN: round-to-nearest-even on the fp16 residual pack (default truncates).
module vexp_range_reduce #(
   parameter int          FRAC_W = 16,
   parameter int          Q_W    = 6,
   parameter logic [16:0] LOG2E  = 17'h17154,
   parameter logic [15:0] LN2    = 16'hB172
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [15:0]    in_x,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [Q_W-1:0] out_q,
   output logic [15:0]    out_r,
   output logic           out_ovf,
   output logic           out_unf,
   output logic           out_nan
);
   localparam int XW  = 1 + 5 + FRAC_W;
   localparam int PW  = XW + 18;
   localparam int TW  = PW - FRAC_W;
   localparam int RW  = 2 * FRAC_W;
   localparam int MW  = 11 + FRAC_W;
   localparam int LZW = $clog2(FRAC_W);
   localparam logic signed [TW-1:0] T_HI = TW'(16) << FRAC_W;
   localparam logic signed [TW-1:0] T_LO = -(TW'(24) << FRAC_W);

   logic [3:1] vld_pipe;
   logic       adv;

   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_pipe[3];

   // S1: fp16 unpack to signed fixed point
   logic                 sgn;
   logic [4:0]           ex;
   logic [9:0]           man;
   logic [MW-1:0]        mag_full;
   logic [XW-1:0]        mag;
   logic signed [XW-1:0] x_n, x1;
   logic                 nan_n, ovf_n, unf_n, nan1, ovf1, unf1;

   assign sgn = in_x[15];
   assign ex  = in_x[14:10];
   assign man = in_x[9:0];

   always_comb begin
      x_n      = '0;
      nan_n    = 1'b0;
      ovf_n    = 1'b0;
      unf_n    = 1'b0;
      mag_full = '0;
      mag      = '0;
      if (ex == 5'd31) begin
         nan_n = (man != 10'd0);
         ovf_n = (man == 10'd0) && !sgn;
         unf_n = (man == 10'd0) && sgn;
      end else if (ex >= 5'd20) begin
         ovf_n = !sgn;
         unf_n = sgn;
      end else if (ex != 5'd0) begin
         mag_full = {1'b1, man, {FRAC_W{1'b0}}} >> (5'd25 - ex);
         mag      = XW'(mag_full);
         x_n      = sgn ? -mag : mag;
      end
   end

   // S2: scale by log2(e), split into floor and fraction
   logic signed [PW-1:0] prod;
   logic signed [TW-1:0] t;
   logic                 ovf_t, unf_t;
   logic [Q_W-1:0]       q_n, q2;
   logic [FRAC_W-1:0]    f_n, f2;
   logic                 nan2, ovf2, unf2;

   always_comb begin
      prod  = PW'(x1) * PW'($signed({1'b0, LOG2E}));
      t     = TW'(prod >>> FRAC_W);
      ovf_t = !nan1 && (ovf1 || (t >= T_HI));
      unf_t = !nan1 && (unf1 || (t < T_LO));
      q_n   = '0;
      f_n   = '0;
      if (!(nan1 || ovf_t || unf_t)) begin
         q_n = t[FRAC_W +: Q_W];
         f_n = t[FRAC_W-1:0];
      end
   end

   // S3: residual = f*ln2, normalised into fp16
   logic [RW-1:0]     rprod;
   logic [FRAC_W-1:0] rf, norm;
   logic [LZW-1:0]    lz;
   logic              found;
   logic [15:0]       r_n;
`ifdef VEXP_RR_ROUND_EN
   logic              rnd;
`endif

   always_comb begin
      rprod = RW'(f2) * RW'(LN2);
      rf    = FRAC_W'(rprod >> FRAC_W);
      lz    = '0;
      found = 1'b0;
      for (int i = FRAC_W - 1; i >= 0; i--) begin
         if (!found && rf[i]) begin
            lz    = LZW'(FRAC_W - 1 - i);
            found = 1'b1;
         end
      end
      norm = rf << lz;
      r_n  = '0;
`ifdef VEXP_RR_ROUND_EN
      rnd  = 1'b0;
`endif
      // a lone lsb would need a negative exponent field; flush it to zero
      if (rf != '0 && lz != LZW'(FRAC_W - 1)) begin
         r_n = {1'b0, 5'(14 - lz), 10'(norm >> (FRAC_W - 11))};
`ifdef VEXP_RR_ROUND_EN
         rnd = norm[FRAC_W-12] && ((|norm[FRAC_W-13:0]) || norm[FRAC_W-11]);
         r_n = r_n + {15'd0, rnd};
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_pipe <= '0;
         x1       <= '0;
         nan1     <= 1'b0;
         ovf1     <= 1'b0;
         unf1     <= 1'b0;
         q2       <= '0;
         f2       <= '0;
         nan2     <= 1'b0;
         ovf2     <= 1'b0;
         unf2     <= 1'b0;
         out_q    <= '0;
         out_r    <= '0;
         out_nan  <= 1'b0;
         out_ovf  <= 1'b0;
         out_unf  <= 1'b0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[2:1], in_valid};
         x1       <= x_n;
         nan1     <= nan_n;
         ovf1     <= ovf_n;
         unf1     <= unf_n;
         q2       <= q_n;
         f2       <= f_n;
         nan2     <= nan1;
         ovf2     <= ovf_t;
         unf2     <= unf_t;
         out_q    <= q2;
         out_r    <= r_n;
         out_nan  <= nan2;
         out_ovf  <= ovf2;
         out_unf  <= unf2;
      end
   end
endmodule

// File: tb/tb_vexp_range_reduce.sv
// Directed bench for vexp_range_reduce: reset, arithmetic vectors, flags, stall, throughput, reset flush.
module tb_vexp_range_reduce;
`ifdef VEXP_RR_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_x, out_r;
   logic [5:0]  out_q;
   logic        out_ovf, out_unf, out_nan;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   vexp_range_reduce dut (
      .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
      .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
      .out_ovf(out_ovf), .out_unf(out_unf), .out_nan(out_nan)
   );

   // x, q, r (truncating pack), r (rounding pack)
   logic [15:0] ax [8] = '{16'h0000, 16'h0001, 16'h3C00, 16'hBC00, 16'h4000, 16'h3800, 16'h4980, 16'hCC00};
   logic [5:0]  aq [8] = '{6'h00, 6'h00, 6'h01, 6'h3E, 6'h02, 6'h00, 6'h0F, 6'h28};
   logic [15:0] at [8] = '{16'h0000, 16'h0000, 16'h34E8, 16'h362E, 16'h38E8, 16'h37FF, 16'h38D2, 16'h3915};
   logic [15:0] ar [8] = '{16'h0000, 16'h0000, 16'h34E9, 16'h362E, 16'h38E9, 16'h3800, 16'h38D2, 16'h3916};

   // special inputs and expected {nan, ovf, unf}
   logic [15:0] sx [8] = '{16'h7E00, 16'hFE00, 16'h7C00, 16'hFC00, 16'h4A00, 16'hCC80, 16'h5000, 16'hD000};
   logic [2:0]  sf [8] = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001};

   function automatic logic [15:0] exp_r(input int i);
      return ROUND ? ar[i] : at[i];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_x = 16'h0; out_ready = 1'b1;
      tick(); tick();
      checks++;
      if (out_valid !== 1'b0 || out_q !== 6'h0 || out_r !== 16'h0 || {out_nan, out_ovf, out_unf} !== 3'b000) begin
         errors++;
         $display("FAIL reset: valid=%b q=%h r=%h flags=%b, required 0/00/0000/000",
                  out_valid, out_q, out_r, {out_nan, out_ovf, out_unf});
      end
      rst = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic test_arith();
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_x = ax[i];
         tick();
         in_valid = 1'b0;
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arith_latency x=%h: out_valid=%b two edges after accept, required 0", ax[i], out_valid);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_q !== aq[i] || out_r !== exp_r(i) || {out_nan, out_ovf, out_unf} !== 3'b000) begin
            errors++;
            $display("FAIL arith x=%h: valid=%b q=%h r=%h flags=%b, required 1/%h/%h/000",
                     ax[i], out_valid, out_q, out_r, {out_nan, out_ovf, out_unf}, aq[i], exp_r(i));
         end
         tick();
      end
   endtask

   task automatic test_flags();
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_x = sx[i];
         tick();
         in_valid = 1'b0;
         tick(); tick();
         checks++;
         if (out_valid !== 1'b1 || out_q !== 6'h0 || out_r !== 16'h0 || {out_nan, out_ovf, out_unf} !== sf[i]) begin
            errors++;
            $display("FAIL flags x=%h: valid=%b q=%h r=%h flags=%b, required 1/00/0000/%b",
                     sx[i], out_valid, out_q, out_r, {out_nan, out_ovf, out_unf}, sf[i]);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      int acc, n, bad;
      logic rdy;
      logic [15:0] vx [4] = '{16'h3C00, 16'hBC00, 16'h4000, 16'h3800};
      int          vi [4] = '{2, 3, 4, 5};
      acc = 0; bad = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1; in_x = vx[acc];
         rdy = in_ready;
         tick();
         if (rdy) acc++;
         if (out_valid === 1'b1 && (out_r !== exp_r(vi[0]) || out_q !== aq[vi[0]])) bad++;
      end
      checks++;
      if (acc != 3) begin
         errors++;
         $display("FAIL stall_accept: accepted %0d, required 3", acc);
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_state: in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stall_stable: %0d unstable cycles, required 0", bad);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 8 && n < 3; c++) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (out_q !== aq[vi[n]] || out_r !== exp_r(vi[n])) begin
               errors++;
               $display("FAIL stall_drain[%0d]: q=%h r=%h, required %h/%h", n, out_q, out_r, aq[vi[n]], exp_r(vi[n]));
            end
            n++;
         end
         tick();
      end
      checks++;
      if (n != 3 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_count: drained %0d then out_valid=%b, required 3 then 0", n, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int vi [4] = '{5, 4, 1, 6};
      int n, first_c, last_c;
      n = 0; first_c = -1; last_c = -1;
      for (int c = 0; c < 12; c++) begin
         if (out_valid === 1'b1 && n < 4) begin
            checks++;
            if (out_q !== aq[vi[n]] || out_r !== exp_r(vi[n])) begin
               errors++;
               $display("FAIL b2b[%0d]: q=%h r=%h, required %h/%h", n, out_q, out_r, aq[vi[n]], exp_r(vi[n]));
            end
            if (first_c < 0) first_c = c;
            last_c = c;
            n++;
         end
         in_valid = (c < 4);
         in_x = (c < 4) ? ax[vi[c]] : 16'h0;
         tick();
      end
      checks++;
      if (n != 4 || first_c != 3 || last_c != 6) begin
         errors++;
         $display("FAIL b2b_timing: count=%0d first=%0d last=%0d, required 4/3/6", n, first_c, last_c);
      end
   endtask

   task automatic test_reset_flight();
      int seen;
      in_valid = 1'b1; in_x = 16'h3C00;
      tick();
      in_x = 16'hBC00;
      tick();
      in_valid = 1'b0; rst = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_q !== 6'h0 || out_r !== 16'h0 || {out_nan, out_ovf, out_unf} !== 3'b000) begin
         errors++;
         $display("FAIL flush_reset: valid=%b q=%h r=%h flags=%b, required all 0",
                  out_valid, out_q, out_r, {out_nan, out_ovf, out_unf});
      end
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (out_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL flush_stale: %0d stale valid cycles, required 0", seen);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_arith();
      test_flags();
      test_stall();
      test_back_to_back();
      test_reset_flight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
